// File: rtl/config_chain_loader.sv
// Transmit end of the configuration shift chain: serializes host words
// LSB-first into the chain, strobes set, and returns the tail bits as readback.
module config_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_shift,
    output logic              cfg_cen,
    output logic              cfg_set,
    input  logic              cfg_tail,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid
);

    localparam int WC_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_rb;
    logic [WORD_W-1:0] r_rb_word;
    logic [WC_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]  r_bits;
    logic              r_shift;
    logic              r_cen;
    logic              r_set;
    logic              r_done;
    logic              r_rb_valid;

    logic [WC_W-1:0]   w_wcnt_nx;
    logic [CNT_W-1:0]  w_bits_nx;
    logic [WORD_W-1:0] w_rb_nx;
    logic [WC_W-1:0]   w_rb_sh;
    logic [WORD_W-1:0] w_rb_just;
    logic              w_last;
    logic              w_leave;

    assign w_wcnt_nx = r_wcnt + WC_W'(1);
    assign w_bits_nx = r_bits + CNT_W'(1);
    assign w_rb_nx   = {cfg_tail, r_rb[WORD_W-1:1]};
    assign w_last    = (w_bits_nx == CNT_W'(CHAIN_LEN));
    assign w_leave   = w_last || (w_wcnt_nx == WC_W'(WORD_W));
    // A short final word sits in the top bits; slide it down to bit 0.
    assign w_rb_sh   = WC_W'(WORD_W) - w_wcnt_nx;
    assign w_rb_just = w_rb_nx >> w_rb_sh;

    assign busy       = (r_state != S_IDLE);
    assign word_ready = (r_state == S_WAIT);
    assign cfg_shift  = r_shift;
    assign cfg_cen    = r_cen;
    assign cfg_set    = r_set;
    assign done       = r_done;
    assign rb_word    = r_rb_word;
    assign rb_valid   = r_rb_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tx       <= '0;
            r_rb       <= '0;
            r_rb_word  <= '0;
            r_wcnt     <= '0;
            r_bits     <= '0;
            r_shift    <= 1'b0;
            r_cen      <= 1'b0;
            r_set      <= 1'b0;
            r_done     <= 1'b0;
            r_rb_valid <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            r_state    <= S_IDLE;
            r_shift    <= 1'b0;
            r_cen      <= 1'b0;
            r_set      <= 1'b0;
            r_done     <= 1'b0;
            r_rb_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_rb_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_WAIT;
                        r_bits  <= '0;
                        r_wcnt  <= '0;
                    end
                end
                S_WAIT: begin
                    r_rb_valid <= 1'b0;
                    if (word_valid) begin
                        r_state <= S_SHIFT;
                        r_shift <= word_in[0];
                        r_tx    <= word_in >> 1;
                        r_cen   <= 1'b1;
                        r_wcnt  <= '0;
                        r_rb    <= '0;
                    end
                end
                S_SHIFT: begin
                    r_rb   <= w_rb_nx;
                    r_wcnt <= w_wcnt_nx;
                    r_bits <= w_bits_nx;
                    if (w_leave) begin
                        r_cen      <= 1'b0;
                        r_shift    <= 1'b0;
                        r_rb_valid <= 1'b1;
                        r_rb_word  <= w_rb_just;
                        if (w_last) begin
                            r_state <= S_SET;
                            r_set   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_shift <= r_tx[0];
                        r_tx    <= r_tx >> 1;
                    end
                end
                S_SET: begin
                    r_state    <= S_DONE;
                    r_set      <= 1'b0;
                    r_done     <= 1'b1;
                    r_rb_valid <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Drives the bitstream configuration shift chain that threads through every tile's connection blocks and CLBs: the transmit end of the `shift_in`/`shift_out`/`cen`/`set_in` protocol. It accepts configuration words from the host over a valid/ready port and serializes them LSB-first into the head of the chain. After exactly CHAIN_LEN bits it pulses the set strobe. It also captures the bits falling out of the chain tail and returns them as readback words, so the host can verify the previous chain contents.

## Interface
- WORD_W, 32, host word width in bits.
- CHAIN_LEN, 1024, total configuration bits in the chain (≥1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  starts a load when sampled high in IDLE; ignored otherwise.
- abort  in  1  returns the block to IDLE from any state except IDLE, with no set pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- word_in  in  WORD_W  configuration word.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  high only in WAIT_WORD.
- cfg_shift  out  1  serial data to the first tile's shift_in.
- cfg_cen  out  1  chain shift enable (all tiles' cen).
- cfg_set  out  1  chain set strobe (all tiles' set_in).
- cfg_tail  in  1  shift_out of the last tile in the chain.
- rb_word  out  WORD_W  readback word.
- rb_valid  out  1  one-cycle pulse; rb_word is valid.

## Operation
- States: IDLE, WAIT_WORD, SHIFT, SET, DONE.
- IDLE -> WAIT_WORD on start. Clears the bit counter (bits_sent) and the readback counter.
- WAIT_WORD: word_ready=1. On word_valid&&word_ready, load word_in into the TX shift register, clear the per-word count, then go to SHIFT.
- SHIFT: cfg_cen=1 every cycle, with cfg_shift=tx[0].
  - On each edge: tx>>=1, rb={cfg_tail, rb[WORD_W-1:1]}, per-word count+1, bits_sent+1.
  - Leave SHIFT when the per-word count reaches WORD_W or bits_sent reaches CHAIN_LEN, whichever comes first.
  - If bits_sent==CHAIN_LEN, go to SET; otherwise go to WAIT_WORD.
- Final partial word: only the low (CHAIN_LEN mod WORD_W) bits are shifted; the upper bits of word_in are discarded.
- Readback: on leaving SHIFT, rb_word is presented with rb_valid=1 for one cycle.
  - A partial final word is right-justified: bit 0 is the first captured bit, and the unused upper bits are 0.
- Bit ordering:
  - Stream bit i equals word i/WORD_W, bit i%WORD_W.
  - After a full load, stream bit 0 occupies the cell nearest cfg_tail.
  - Readback stream bit i is the value of cfg_tail at the i-th shift edge, i.e. the old chain contents, tail-most first.
- SET: cfg_set=1 and cfg_cen=0 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- abort: takes effect at the next edge.
  - Goes to IDLE; cfg_cen, cfg_set, word_ready and rb_valid drop.
  - done is not pulsed.
  - Any rb_valid pending for the aborted word is suppressed.
  - The chain holds partial data but is never set.
- Reset mid-operation behaves like abort, asynchronously.
- Reset values: state=IDLE; busy, done, word_ready, cfg_shift, cfg_cen, cfg_set, rb_valid = 0; rb_word = 0.
- cfg_shift is 0 whenever cfg_cen=0.

## Timing
- All outputs are registered except word_ready and busy, which are decoded from the state register.
- Word handshake completes at edge T. SHIFT occupies cycles T+1 .. T+WORD_W, with cfg_cen high exactly those cycles.
- rb_valid is asserted in cycle T+WORD_W+1, coinciding with WAIT_WORD (word_ready=1) or SET.
- Throughput: WORD_W+1 cycles per full word, given word_valid already high.
- Full load with valid always high takes 1 (IDLE->WAIT) + N_words×1 + CHAIN_LEN + 1 (SET) + 1 (DONE) cycles from start to the end of the done cycle.
- The number of cfg_cen-high cycles per completed load is exactly CHAIN_LEN.
- Stalls: word_valid low in WAIT_WORD holds the state indefinitely, with cfg_cen=0. The chain retains its contents.
- start arriving in the same cycle as done is ignored. The block is in DONE that cycle and reaches IDLE next cycle.
- Simultaneous abort and start while in IDLE: start wins (abort is a no-op in IDLE).

## Test plan
- Basic load, WORD_W=32, CHAIN_LEN=40, words 0xA5A5_0F0F then 0x0000_00C3 → 40 cfg_cen cycles.
  - cfg_shift sequence is the LSB-first bits of 0x0F0F, then 0xA5A5, then 0xC3.
  - One cfg_set pulse, then done.
  - A behavioral 40-bit chain model holds 0xC3_A5A50F0F.
- Readback: preload the model chain with 0x12_3456_789A, then load any data.
  - rb_word = 0x3456789A (first) and 0x00000012 (second, partial).
- Backpressure: word_valid low for 7 cycles in WAIT_WORD.
  - No cfg_cen during the gap; the final chain contents are identical to the no-stall run.
- Exact multiple, CHAIN_LEN=64: two words → exactly 64 cen cycles; no WAIT_WORD after the second word; SET follows directly.
- Abort after 10 shift cycles → IDLE next cycle; cfg_set never asserted; no done; no rb_valid for that word.
  - A new start then loads correctly.
- Async reset asserted mid-SHIFT → all outputs 0 immediately; state IDLE after release.
  - A start while busy is ignored; busy is high and word_ready follows the state only.
